fir_band_scheduler: RTL and testbench

//  Time-shares one FIR MAC engine across NUM_BANDS equalizer bands once per new sample pair.
//  For each enabled band: selects the coefficient bank, rewinds the sample queue, drives the
//  FIR "sequencing" strobe, then captures the band's L/R result.

---
 rtl/eq_pkg.sv | 20 ++
 rtl/eq_next_band.sv | 36 +++
 rtl/fir_band_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_fir_band_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types and limits for the equalizer band scheduler
//
// Purpose: common scheduler state encoding, band index type and the upper
// bound on band count that a 3-bit band index can address.

package eq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    START,
    RUN,
    DRAIN
  } sched_state_t;

  typedef logic [2:0] band_idx_t;

  localparam int NUM_BANDS_MAX = 8;

endpackage

// File: rtl/eq_next_band.sv
// rtl/eq_next_band.sv - finds the lowest enabled band strictly above a given index
//
// Purpose: combinational search over the latched enable mask. With i_none set
// the search starts from band 0 (no band served yet in this frame).
// Ports:
//   i_en     in  NUM_BANDS  latched per-band enable mask
//   i_cur    in  3          index of the band just served
//   i_none   in  1          no band served yet; ignore i_cur
//   o_found  out 1          an eligible band exists
//   o_idx    out 3          lowest eligible band index (0 when none)

module eq_next_band
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5
) (
  input  logic [NUM_BANDS-1:0] i_en,
  input  band_idx_t            i_cur,
  input  logic                 i_none,
  output logic                 o_found,
  output band_idx_t            o_idx
);

  // Scan from the top down so the lowest eligible band is the last written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (i_en[i] && (i_none || (i > int'(i_cur)))) begin
        o_found = 1'b1;
        o_idx   = band_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/fir_band_scheduler.sv
// rtl/fir_band_scheduler.sv - time-shares one FIR MAC engine across equalizer bands
//
// Purpose: on each new sample pair, walks the enabled bands lowest first; for
// each one selects the coefficient bank, rewinds the sample queue, strobes the
// shared FIR for NTAPS+1 cycles and captures the band's L/R result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   new_smpl            frame start pulse
//   band_en             per-band enable, latched at frame start
//   clr_ovr             clears the sticky overrun flag
//   fir_lft, fir_rght   shared FIR results
//   band_sel            coefficient bank select
//   fir_seq             FIR sequencing strobe
//   smp_rewind          queue read pointer rewind pulse
//   smp_rd_en           queue read advance
//   res_vld/band/lft/rght  captured band result, res_vld pulses once per band
//   frame_done          all enabled bands of the frame completed
//   busy                scheduler not idle
//   overrun             sticky: new_smpl seen while busy

module fir_band_scheduler
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5,
  parameter int NTAPS     = 1021
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_smpl,
  input  logic [NUM_BANDS-1:0] band_en,
  input  logic                 clr_ovr,
  input  logic [15:0]          fir_lft,
  input  logic [15:0]          fir_rght,
  output logic [2:0]           band_sel,
  output logic                 fir_seq,
  output logic                 smp_rewind,
  output logic                 smp_rd_en,
  output logic                 res_vld,
  output logic [2:0]           res_band,
  output logic [15:0]          res_lft,
  output logic [15:0]          res_rght,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TW = $clog2(NTAPS + 1);

  sched_state_t         r_state;
  sched_state_t         w_next;
  logic [NUM_BANDS-1:0] r_en_q;
  band_idx_t            r_band_sel;
  logic                 r_first;
  logic [TW-1:0]        r_tap_cnt;
  logic                 r_res_vld;
  band_idx_t            r_res_band;
  logic [15:0]          r_res_lft;
  logic [15:0]          r_res_rght;
  logic                 r_overrun;
  logic                 w_found;
  band_idx_t            w_idx;
  logic                 w_last_tap;

  eq_next_band #(
    .NUM_BANDS (NUM_BANDS)
  ) u_next_band (
    .i_en    (r_en_q),
    .i_cur   (r_band_sel),
    .i_none  (r_first),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_last_tap = (r_tap_cnt == TW'(NTAPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes are decoded from state so reset removes them without waiting
  // for a clock edge.
  always_comb begin
    w_next     = r_state;
    frame_done = 1'b0;
    smp_rewind = 1'b0;
    fir_seq    = 1'b0;
    smp_rd_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (new_smpl) begin
          w_next = PICK;
        end
      end
      PICK: begin
        if (w_found) begin
          w_next = START;
        end else begin
          frame_done = 1'b1;
          w_next     = IDLE;
        end
      end
      START: begin
        smp_rewind = 1'b1;
        w_next     = RUN;
      end
      RUN: begin
        fir_seq = 1'b1;
        // Cycle 0 of RUN is the FIR accumulator clear; no sample consumed.
        smp_rd_en = (r_tap_cnt != '0);
        if (w_last_tap) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = PICK;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_q     <= '0;
      r_band_sel <= '0;
      r_first    <= 1'b0;
      r_tap_cnt  <= '0;
      r_res_vld  <= 1'b0;
      r_res_band <= '0;
      r_res_lft  <= '0;
      r_res_rght <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (new_smpl) begin
            r_en_q  <= band_en;
            r_first <= 1'b1;
          end
        end
        PICK: begin
          if (w_found) begin
            r_band_sel <= w_idx;
            r_first    <= 1'b0;
          end
        end
        START: begin
          r_tap_cnt <= '0;
        end
        RUN: begin
          if (!w_last_tap) begin
            r_tap_cnt <= r_tap_cnt + TW'(1);
          end
        end
        DRAIN: begin
          r_res_lft  <= fir_lft;
          r_res_rght <= fir_rght;
          r_res_band <= r_band_sel;
          r_res_vld  <= 1'b1;
        end
        default: begin
        end
      endcase

      // A fresh overrun event takes priority over a coincident clear.
      if (new_smpl && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign band_sel = r_band_sel;
  assign res_vld  = r_res_vld;
  assign res_band = r_res_band;
  assign res_lft  = r_res_lft;
  assign res_rght = r_res_rght;
  assign busy     = (r_state != IDLE);
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_fir_band_scheduler.sv
// tb/tb_fir_band_scheduler.sv - scoreboard bench for fir_band_scheduler

module tb_fir_band_scheduler;

  localparam int NB       = 5;
  localparam int NT       = 8;
  localparam int BAND_CYC = NT + 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          new_smpl = 1'b0;
  logic [NB-1:0] band_en  = '0;
  logic          clr_ovr  = 1'b0;
  logic [15:0]   fir_lft;
  logic [15:0]   fir_rght;
  logic [2:0]    band_sel;
  logic          fir_seq;
  logic          smp_rewind;
  logic          smp_rd_en;
  logic          res_vld;
  logic [2:0]    res_band;
  logic [15:0]   res_lft;
  logic [15:0]   res_rght;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  fir_band_scheduler #(
    .NUM_BANDS (NB),
    .NTAPS     (NT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_smpl   (new_smpl),
    .band_en    (band_en),
    .clr_ovr    (clr_ovr),
    .fir_lft    (fir_lft),
    .fir_rght   (fir_rght),
    .band_sel   (band_sel),
    .fir_seq    (fir_seq),
    .smp_rewind (smp_rewind),
    .smp_rd_en  (smp_rd_en),
    .res_vld    (res_vld),
    .res_band   (res_band),
    .res_lft    (res_lft),
    .res_rght   (res_rght),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int band;
    int lft;
    int rght;
    int at;
  } res_t;

  res_t res_q[$];
  int   fd_q[$];
  int   fr_start = 1;
  int   fr_end   = 0;

  logic [15:0] smp_l[16];
  logic [15:0] smp_r[16];

  // Behavioural shared FIR: clear on sequencing entry, add one queued
  // sample (coefficient 1) per read advance.
  logic [3:0]  rd_ptr   = '0;
  logic [15:0] acc_l    = '0;
  logic [15:0] acc_r    = '0;
  logic        prev_seq = 1'b0;

  always @(posedge clk) begin
    if (smp_rewind) rd_ptr <= '0;
    if (fir_seq && !prev_seq) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (smp_rd_en) begin
      acc_l  <= acc_l + smp_l[rd_ptr];
      acc_r  <= acc_r + smp_r[rd_ptr];
      rd_ptr <= rd_ptr + 4'd1;
    end
    prev_seq <= fir_seq;
  end

  assign fir_lft  = acc_l;
  assign fir_rght = acc_r;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: enabled bands served in ascending order, each taking
  // PICK+START+RUN(NT+1)+DRAIN cycles; result is the plain sum of the
  // first NT queued samples; frame ends with one final PICK.
  task automatic plan_frame(input logic [NB-1:0] en, input int s);
    int j;
    int sl;
    int sr;
    res_t r;
    j  = 0;
    sl = 0;
    sr = 0;
    for (int i = 0; i < NT; i++) begin
      sl += int'(smp_l[i]);
      sr += int'(smp_r[i]);
    end
    for (int b = 0; b < NB; b++) begin
      if (en[b]) begin
        r.band = b;
        r.lft  = sl & 32'hFFFF;
        r.rght = sr & 32'hFFFF;
        r.at   = s + 1 + BAND_CYC * (j + 1);
        res_q.push_back(r);
        j++;
      end
    end
    fd_q.push_back(s + 1 + BAND_CYC * j);
    fr_start = s + 1;
    fr_end   = s + 1 + BAND_CYC * j;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_frame(input logic [NB-1:0] en);
    @(negedge clk);
    band_en  = en;
    new_smpl = 1'b1;
    plan_frame(en, cyc);
    @(negedge clk);
    new_smpl = 1'b0;
  endtask

  task automatic finish_frame();
    wait_cyc(fr_end + 2);
    check("res_queue_drained", res_q.size(), 0);
    check("frame_done_queue_drained", fd_q.size(), 0);
  endtask

  task automatic rand_samples();
    for (int i = 0; i < 16; i++) begin
      smp_l[i] = 16'($urandom_range(0, 2000));
      smp_r[i] = 16'($urandom_range(0, 2000));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    int   fseq_cnt;
    int   rd_cnt;
    bit   rew_seen;
    res_t r;
    int   fd_at;
    fseq_cnt = 0;
    rd_cnt   = 0;
    rew_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", int'(busy), int'(cyc >= fr_start && cyc <= fr_end));
        if (smp_rewind) begin
          if (res_q.size() == 0) check("smp_rewind_unexpected", 1, 0);
          else check("band_sel_at_rewind", int'(band_sel), res_q[0].band);
          fseq_cnt = 0;
          rd_cnt   = 0;
          rew_seen = 1'b1;
        end
        if (fir_seq) begin
          fseq_cnt++;
          if (res_q.size() == 0) check("fir_seq_unexpected", 1, 0);
          else check("band_sel_stable", int'(band_sel), res_q[0].band);
        end
        if (smp_rd_en) rd_cnt++;
        if (res_vld) begin
          if (res_q.size() == 0) begin
            check("res_vld_unexpected", 1, 0);
          end else begin
            r = res_q.pop_front();
            check("res_band", int'(res_band), r.band);
            check("res_lft", int'(res_lft), r.lft);
            check("res_rght", int'(res_rght), r.rght);
            check("res_vld_cycle", cyc, r.at);
            check("fir_seq_len", fseq_cnt, NT + 1);
            check("smp_rd_en_len", rd_cnt, NT);
            check("rewind_before_band", int'(rew_seen), 1);
            rew_seen = 1'b0;
          end
        end
        if (frame_done) begin
          if (fd_q.size() == 0) begin
            check("frame_done_unexpected", 1, 0);
          end else begin
            fd_at = fd_q.pop_front();
            check("frame_done_cycle", cyc, fd_at);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    logic [NB-1:0] en;
    rand_samples();
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_fir_seq", int'(fir_seq), 0);
    check("reset_res_vld", int'(res_vld), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_band_sel", int'(band_sel), 0);
    check("reset_res_lft", int'(res_lft), 0);
    check("reset_smp_rewind", int'(smp_rewind), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // all bands
    start_frame(5'b11111);
    finish_frame();

    // sparse mask and empty mask
    rand_samples();
    start_frame(5'b10010);
    finish_frame();
    start_frame(5'b00000);
    finish_frame();

    // overrun during RUN of band 2, then clear
    rand_samples();
    start_frame(5'b11111);
    s = fr_start - 1;
    wait_cyc(s + 1 + 2 * BAND_CYC + 3);
    new_smpl = 1'b1;
    @(negedge clk);
    new_smpl = 1'b0;
    check("overrun_set", int'(overrun), 1);
    finish_frame();
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("overrun_cleared", int'(overrun), 0);

    // overrun on the frame_done cycle
    start_frame(5'b00001);
    wait_cyc(fr_end);
    new_smpl = 1'b1;
    @(negedge clk);
    new_smpl = 1'b0;
    check("overrun_on_frame_done", int'(overrun), 1);
    finish_frame();
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("overrun_cleared2", int'(overrun), 0);

    // set and clear in the same cycle: set wins
    start_frame(5'b00111);
    wait_cyc(fr_start + 5);
    new_smpl = 1'b1;
    clr_ovr  = 1'b1;
    @(negedge clk);
    new_smpl = 1'b0;
    clr_ovr  = 1'b0;
    check("overrun_set_wins", int'(overrun), 1);
    finish_frame();
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("overrun_cleared3", int'(overrun), 0);

    // random masks with band_en toggled mid-frame
    for (int f = 0; f < 10; f++) begin
      rand_samples();
      en = NB'($urandom);
      start_frame(en);
      wait_cyc(cyc + int'($urandom_range(0, 40)));
      band_en = NB'($urandom);
      finish_frame();
    end

    // reset in RUN of band 3
    rand_samples();
    start_frame(5'b11111);
    wait_cyc(fr_start + 3 * BAND_CYC + 4);
    rst_n = 1'b0;
    #1;
    check("abort_fir_seq", int'(fir_seq), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_smp_rd_en", int'(smp_rd_en), 0);
    check("abort_band_sel", int'(band_sel), 0);
    check("abort_res_lft", int'(res_lft), 0);
    check("abort_res_vld", int'(res_vld), 0);
    res_q.delete();
    fd_q.delete();
    fr_end = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(5'b11111);
    finish_frame();

    // ramp 1..8: every band sums to 36 left, 72 right
    rand_samples();
    for (int i = 0; i < NT; i++) begin
      smp_l[i] = 16'(i + 1);
      smp_r[i] = 16'(2 * (i + 1));
    end
    start_frame(5'b11111);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
